// File: rtl/stack_sequencer.sv
// Downward-growing hardware stack controller: pre-decrement push, post-increment pop,
// with an external pointer stage and a synchronous-read stack RAM.
module stack_sequencer #(
   parameter int N = 9,
   parameter int W = 16,
   parameter logic [N-1:0] SP_INIT = 9'h1FF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         psh_req,
   input  logic         pop_req,
   input  logic [W-1:0] push_data,
   output logic         ready,
   output logic         done,
   output logic         err,
   output logic [W-1:0] pop_data,
   output logic         sp_psh,
   output logic         sp_pop,
   output logic [N-1:0] sp_d,
   input  logic [N-1:0] sp_q,
   output logic [N-1:0] mem_addr,
   output logic [W-1:0] mem_wdata,
   output logic         mem_we,
   output logic         mem_re,
   input  logic [W-1:0] mem_rdata,
   output logic         full,
   output logic         empty
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PUSH_DEC = 3'd1,
      PUSH_WR  = 3'd2,
      POP_RD   = 3'd3,
      POP_INC  = 3'd4,
      ERR      = 3'd5
   } state_t;

   state_t         state_r;
   state_t         state_s;
   logic [N-1:0]   sp_r;
   logic [W-1:0]   data_r;
   logic [W-1:0]   pop_data_r;
   logic           done_r;
   logic           err_r;
   logic           err_wait_r;
   logic           finish_s;
   logic           full_s;
   logic           empty_s;

   assign full_s  = (sp_r == {N{1'b0}});
   assign empty_s = (sp_r == SP_INIT);

   // Next-state decode; ERR holds for two cycles so rejects match the push/pop latency.
   always_comb begin
      state_s  = state_r;
      finish_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (psh_req) begin
               state_s = full_s ? ERR : PUSH_DEC;
            end else if (pop_req) begin
               state_s = empty_s ? ERR : POP_RD;
            end else begin
               state_s = IDLE;
            end
         end
         PUSH_DEC: state_s = PUSH_WR;
         PUSH_WR: begin
            state_s  = IDLE;
            finish_s = 1'b1;
         end
         POP_RD: state_s = POP_INC;
         POP_INC: begin
            state_s  = IDLE;
            finish_s = 1'b1;
         end
         ERR: begin
            if (err_wait_r) begin
               state_s  = IDLE;
               finish_s = 1'b1;
            end else begin
               state_s  = ERR;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // State, pointer, captured word, popped word and completion flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         sp_r       <= SP_INIT;
         data_r     <= {W{1'b0}};
         pop_data_r <= {W{1'b0}};
         done_r     <= 1'b0;
         err_r      <= 1'b0;
         err_wait_r <= 1'b0;
      end else begin
         state_r    <= state_s;
         done_r     <= finish_s;
         err_r      <= finish_s && (state_r == ERR);
         err_wait_r <= (state_r == ERR) && !err_wait_r;
         if ((state_r == IDLE) && psh_req && !full_s) begin
            data_r <= push_data;
         end
         if ((state_r == PUSH_DEC) || (state_r == POP_INC)) begin
            sp_r <= sp_q;
         end
         if (state_r == POP_INC) begin
            pop_data_r <= mem_rdata;
         end
      end
   end

   assign ready     = (state_r == IDLE);
   assign done      = done_r;
   assign err       = err_r;
   assign pop_data  = pop_data_r;
   assign sp_psh    = (state_r == PUSH_DEC);
   assign sp_pop    = (state_r == POP_INC);
   assign sp_d      = sp_r;
   assign mem_addr  = sp_r;
   assign mem_wdata = data_r;
   assign mem_we    = (state_r == PUSH_WR);
   assign mem_re    = (state_r == POP_RD);
   assign full      = full_s;
   assign empty     = empty_s;

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: directed vector table, full/reset corners, and random
// push/pop traffic checked against a queue-based stack model.
module tb_stack_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        psh_req = 1'b0;
   logic        pop_req = 1'b0;
   logic [15:0] push_data = 16'h0000;
   logic        ready, done, err, sp_psh, sp_pop, mem_we, mem_re, full, empty;
   logic [15:0] pop_data, mem_wdata;
   logic [15:0] mem_rdata = 16'h0000;
   logic [8:0]  sp_d, sp_q, mem_addr;

   logic [15:0] ram [0:511];
   int          we_cnt = 0;
   int          re_cnt = 0;
   int          done_cnt = 0;
   int          both_cnt = 0;
   int          n_checks = 0;
   int          n_fail = 0;

   stack_sequencer dut (
      .clk(clk), .rst_n(rst_n), .psh_req(psh_req), .pop_req(pop_req),
      .push_data(push_data), .ready(ready), .done(done), .err(err),
      .pop_data(pop_data), .sp_psh(sp_psh), .sp_pop(sp_pop), .sp_d(sp_d),
      .sp_q(sp_q), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_re(mem_re), .mem_rdata(mem_rdata), .full(full), .empty(empty)
   );

   always #5 clk = ~clk;

   assign sp_q = sp_psh ? (sp_d - 9'd1) : (sp_pop ? (sp_d + 9'd1) : sp_d);

   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= ram[mem_addr];
      if (mem_we) we_cnt <= we_cnt + 1;
      if (mem_re) re_cnt <= re_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (sp_psh && sp_pop) both_cnt <= both_cnt + 1;
   end

   typedef struct {
      logic        psh;
      logic        pop;
      logic [15:0] data;
      logic        exp_err;
      logic [15:0] exp_pd;
      logic [8:0]  exp_sp;
      logic        exp_empty;
   } vec_t;

   vec_t        vecs [10];
   logic [15:0] model_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      psh_req = 1'b0;
      pop_req = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One transaction; o_lat is the cycle (1 = cycle right after the accept edge) showing done.
   task automatic do_op(input logic p, input logic q, input logic [15:0] d, input logic noise,
                        output logic o_err, output int o_lat, output int o_we, output int o_re);
      int k;
      int we0;
      int re0;
      k = 0;
      while (!ready && k < 10) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("ready_before_op", {31'd0, ready}, 32'd1);
      @(negedge clk);
      psh_req = p;
      pop_req = q;
      push_data = d;
      we0 = we_cnt;
      re0 = re_cnt;
      @(posedge clk);
      #1;
      psh_req = 1'b0;
      pop_req = 1'b0;
      if (noise) begin
         psh_req = 1'($urandom);
         pop_req = 1'($urandom);
         push_data = 16'($urandom);
      end
      o_lat = 1;
      while (!done && o_lat < 8) begin
         @(posedge clk);
         #1;
         o_lat++;
         psh_req = 1'b0;
         pop_req = 1'b0;
      end
      o_err = err;
      o_we = we_cnt - we0;
      o_re = re_cnt - re0;
      @(posedge clk);
      #1;
      check("done_one_cycle", {31'd0, done}, 32'd0);
   endtask

   initial begin
      logic        e;
      int          lat, dwe, dre, we0, d0;
      logic        mp, mq, exp_e;
      logic [15:0] md, exp_pd;

      vecs[0] = '{1'b0, 1'b1, 16'h0000, 1'b1, 16'h0000, 9'h1FF, 1'b1};
      vecs[1] = '{1'b1, 1'b0, 16'hBEEF, 1'b0, 16'h0000, 9'h1FE, 1'b0};
      vecs[2] = '{1'b1, 1'b1, 16'h2222, 1'b0, 16'h0000, 9'h1FD, 1'b0};
      vecs[3] = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'h2222, 9'h1FE, 1'b0};
      vecs[4] = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'hBEEF, 9'h1FF, 1'b1};
      vecs[5] = '{1'b1, 1'b0, 16'h1111, 1'b0, 16'hBEEF, 9'h1FE, 1'b0};
      vecs[6] = '{1'b1, 1'b0, 16'h2222, 1'b0, 16'hBEEF, 9'h1FD, 1'b0};
      vecs[7] = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'h2222, 9'h1FE, 1'b0};
      vecs[8] = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'h1111, 9'h1FF, 1'b1};
      vecs[9] = '{1'b0, 1'b1, 16'h0000, 1'b1, 16'h1111, 9'h1FF, 1'b1};

      do_reset();
      #1;
      check("rst_ready", {31'd0, ready}, 32'd1);
      check("rst_empty", {31'd0, empty}, 32'd1);
      check("rst_full", {31'd0, full}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_sp", {23'd0, sp_d}, 32'h1FF);
      check("rst_pop_data", {16'd0, pop_data}, 32'd0);

      for (int i = 0; i < 10; i++) begin
         do_op(vecs[i].psh, vecs[i].pop, vecs[i].data, 1'b0, e, lat, dwe, dre);
         check("vec_err", {31'd0, e}, {31'd0, vecs[i].exp_err});
         check("vec_latency", lat, 32'd3);
         check("vec_pop_data", {16'd0, pop_data}, {16'd0, vecs[i].exp_pd});
         check("vec_sp", {23'd0, sp_d}, {23'd0, vecs[i].exp_sp});
         check("vec_empty", {31'd0, empty}, {31'd0, vecs[i].exp_empty});
         check("vec_we", dwe, (vecs[i].psh && !vecs[i].exp_err) ? 32'd1 : 32'd0);
         check("vec_re", dre, (!vecs[i].psh && vecs[i].pop && !vecs[i].exp_err) ? 32'd1 : 32'd0);
         if (i == 1) check("ram_1fe_beef", {16'd0, ram[9'h1FE]}, 32'hBEEF);
      end

      // Fill to capacity, then one rejected push and one pop of the top word.
      do_reset();
      for (int i = 0; i < 511; i++) begin
         do_op(1'b1, 1'b0, 16'(i) ^ 16'hA5A5, 1'b0, e, lat, dwe, dre);
         check("fill_err", {31'd0, e}, 32'd0);
      end
      check("full_flag", {31'd0, full}, 32'd1);
      check("full_sp", {23'd0, sp_d}, 32'd0);
      do_op(1'b1, 1'b0, 16'hDEAD, 1'b0, e, lat, dwe, dre);
      check("overflow_err", {31'd0, e}, 32'd1);
      check("overflow_latency", lat, 32'd3);
      check("overflow_we", dwe, 32'd0);
      check("overflow_sp", {23'd0, sp_d}, 32'd0);
      do_op(1'b0, 1'b1, 16'h0000, 1'b0, e, lat, dwe, dre);
      check("top_pop_data", {16'd0, pop_data}, {16'd0, 16'd510 ^ 16'hA5A5});
      check("top_pop_sp", {23'd0, sp_d}, 32'd1);

      // Reset while in PUSH_DEC aborts the push with no write and no done.
      do_reset();
      @(negedge clk);
      psh_req = 1'b1;
      push_data = 16'h5A5A;
      we0 = we_cnt;
      d0 = done_cnt;
      @(posedge clk);
      #1;
      psh_req = 1'b0;
      check("abort_in_dec", {31'd0, sp_psh}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_ready", {31'd0, ready}, 32'd1);
      check("abort_sp_psh", {31'd0, sp_psh}, 32'd0);
      check("abort_sp", {23'd0, sp_d}, 32'h1FF);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("abort_no_we", we_cnt - we0, 32'd0);
      check("abort_no_done", done_cnt - d0, 32'd0);
      check("abort_sp_after", {23'd0, sp_d}, 32'h1FF);

      // Random traffic against a queue model; noise requests during busy cycles must be ignored.
      do_reset();
      model_q.delete();
      exp_pd = 16'h0000;
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 3))
            0, 1:    begin mp = 1'b1; mq = 1'b0; end
            2:       begin mp = 1'b0; mq = 1'b1; end
            default: begin mp = 1'b1; mq = 1'b1; end
         endcase
         md = 16'($urandom);
         exp_e = 1'b0;
         if (mp) begin
            if (model_q.size() == 511) exp_e = 1'b1;
            else model_q.push_back(md);
         end else begin
            if (model_q.size() == 0) exp_e = 1'b1;
            else exp_pd = model_q.pop_back();
         end
         do_op(mp, mq, md, 1'b1, e, lat, dwe, dre);
         check("rnd_err", {31'd0, e}, {31'd0, exp_e});
         check("rnd_latency", lat, 32'd3);
         check("rnd_pop_data", {16'd0, pop_data}, {16'd0, exp_pd});
         check("rnd_sp", {23'd0, sp_d}, 32'h1FF - model_q.size());
         check("rnd_empty", {31'd0, empty}, (model_q.size() == 0) ? 32'd1 : 32'd0);
         check("rnd_we", dwe, (mp && !exp_e) ? 32'd1 : 32'd0);
         check("rnd_re", dre, (!mp && !exp_e) ? 32'd1 : 32'd0);
      end
      check("psh_pop_exclusive", both_cnt, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
